// File: rtl/sign_narrow_pkg.sv
// Shared types and constants for the sign_narrow 32-to-16 signed narrowing unit.
package sign_narrow_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } narrow_state_t;

    localparam logic [15:0] NARROW_MAX = 16'h7FFF;
    localparam logic [15:0] NARROW_MIN = 16'h8000;

    typedef struct packed {
        logic [15:0] data;
        logic        ovf;
    } narrow_word_t;

endpackage

// File: rtl/sign_narrow_if.sv
// Valid/ready stream bundle for sign_narrow: 32-bit words in, narrowed 16-bit words out.
interface sign_narrow_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );

endinterface

// File: rtl/sign_narrow_narrow_check.sv
// Combinational fit check and narrowing of a 32-bit word to narrow_word_t.
// Build option: SIGN_NARROW_SAT_EN selects saturation instead of wrap on overflow.
module narrow_check
    import sign_narrow_pkg::*;
(
    input  logic [31:0]  data_i,
    output narrow_word_t word_o
);

    logic fit;

    // Fits in 16 bits signed when bits 31..15 are all copies of the sign.
    assign fit = (&data_i[31:15]) | ~(|data_i[31:15]);

    always_comb begin
        word_o.ovf  = ~fit;
        word_o.data = data_i[15:0];
`ifdef SIGN_NARROW_SAT_EN
        if (!fit) begin
            word_o.data = data_i[31] ? NARROW_MIN : NARROW_MAX;
        end
`endif
    end

endmodule

// File: rtl/sign_narrow.sv
// Streaming 32-to-16 signed narrowing unit with a 2-entry skid buffer and overflow counter.
// Build option: SIGN_NARROW_SAT_EN (saturate on overflow, otherwise wrap).
module sign_narrow
    import sign_narrow_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    sign_narrow_if.slave     bus,
    input  logic             clear_count,
    output logic [CNT_W-1:0] ovf_count
);

    narrow_state_t state_q, state_d;
    narrow_word_t  new_word;
    narrow_word_t  out_q, out_d;
    narrow_word_t  skid_q, skid_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic          accept;
    logic          consume;

    narrow_check u_check (
        .data_i (bus.in_data),
        .word_o (new_word)
    );

    assign accept  = bus.in_valid && in_ready_q;
    assign consume = out_valid_q && bus.out_ready;

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        skid_d      = skid_q;
        out_valid_d = out_valid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    out_d       = new_word;
                    out_valid_d = 1'b1;
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    out_d = new_word;
                end else if (accept) begin
                    skid_d  = new_word;
                    state_d = TWO;
                end else if (consume) begin
                    out_valid_d = 1'b0;
                    state_d     = EMPTY;
                end
            end
            TWO: begin
                if (consume) begin
                    out_d   = skid_q;
                    state_d = ONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = EMPTY;
            end
        endcase
    end

    // Registered ready looks at the next state, so out_ready never reaches in_ready combinationally.
    assign in_ready_d = (state_d != TWO);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_count) begin
            cnt_d = '0;
        end else if (accept && new_word.ovf && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_q.data;
    assign bus.out_ovf   = out_q.ovf;
    assign ovf_count     = cnt_q;

endmodule

// File: tb/tb_sign_narrow.sv
// Bench for sign_narrow: directed cases plus random traffic against a queue-based reference.
module tb_sign_narrow;
    import sign_narrow_pkg::*;

    typedef struct {
        logic [15:0] d;
        logic        o;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear_count;
    logic [15:0] cnt16;
    logic [1:0]  cnt2;

    sign_narrow_if bus ();
    sign_narrow_if sbus ();

    always #5 clk = ~clk;

    sign_narrow #(.CNT_W(16)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .clear_count (clear_count),
        .ovf_count   (cnt16)
    );

    sign_narrow #(.CNT_W(2)) u_sat (
        .clk         (clk),
        .reset       (reset),
        .bus         (sbus.slave),
        .clear_count (clear_count),
        .ovf_count   (cnt2)
    );

    assign sbus.in_valid  = bus.in_valid;
    assign sbus.in_data   = bus.in_data;
    assign sbus.out_ready = bus.out_ready;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    exp_t        q[$];
    bit          m_rdy = 1'b0;
    int unsigned m_cnt16 = 0;
    int unsigned m_cnt2 = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_narrow(input logic [31:0] d);
        exp_t   e;
        longint v;
        v   = longint'($signed(d));
        e.o = (v > 32767) || (v < -32768);
        e.d = d[15:0];
`ifdef SIGN_NARROW_SAT_EN
        if (e.o) e.d = (v < 0) ? 16'h8000 : 16'h7FFF;
`endif
        return e;
    endfunction

    task automatic cycle(input bit v, input logic [31:0] d, input bit ordy,
                         input bit clr, input bit rst);
        bit   acc;
        bit   cons;
        exp_t e;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        clear_count   = clr;
        reset         = rst;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_rdy   = 1'b0;
            m_cnt16 = 0;
            m_cnt2  = 0;
        end else begin
            acc  = v && m_rdy;
            cons = (q.size() != 0) && ordy;
            e    = ref_narrow(d);
            if (cons) void'(q.pop_front());
            if (acc) q.push_back(e);
            m_rdy = (q.size() < 2);
            if (clr) begin
                m_cnt16 = 0;
                m_cnt2  = 0;
            end else if (acc && e.o) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
        @(negedge clk);
        check("in_ready", 32'(bus.in_ready), 32'(m_rdy));
        check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        check("w2_out_valid", 32'(sbus.out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("out_data", 32'(bus.out_data), 32'(q[0].d));
            check("out_ovf", 32'(bus.out_ovf), 32'(q[0].o));
        end
        check("ovf_count", 32'(cnt16), m_cnt16);
        check("ovf_count_w2", 32'(cnt2), m_cnt2);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 4))
            0:       return {{16{r[15]}}, r[15:0]};
            1: begin
                case (r[2:0])
                    3'd0:    return 32'h0000_7FFF;
                    3'd1:    return 32'h0000_8000;
                    3'd2:    return 32'hFFFF_8000;
                    3'd3:    return 32'hFFFF_7FFF;
                    3'd4:    return 32'h7FFF_FFFF;
                    3'd5:    return 32'h8000_0000;
                    3'd6:    return 32'hFFFF_FFFF;
                    default: return 32'h0000_0000;
                endcase
            end
            2:       return {r[31] ? 16'hFFFF : 16'h0000, r[15:0]};
            3:       return {15'h0000, r[16:0]};
            default: return r;
        endcase
    endfunction

    logic [31:0] stream_in [4];
    logic [15:0] stream_out[4];

    initial begin
        stream_in[0]  = 32'h0000_1234;
        stream_in[1]  = 32'hFFFF_8000;
        stream_in[2]  = 32'h0000_7FFF;
        stream_in[3]  = 32'hFFFF_FFFF;
        stream_out[0] = 16'h1234;
        stream_out[1] = 16'h8000;
        stream_out[2] = 16'h7FFF;
        stream_out[3] = 16'hFFFF;

        // reset for two cycles, ready rises on the next one
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_count", 32'(cnt16), 32'd0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("post_rst_ready", 32'(bus.in_ready), 32'd1);

        // in-range stream at full rate
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, stream_in[i], 1'b1, 1'b0, 1'b0);
            check("stream_data", 32'(bus.out_data), 32'(stream_out[i]));
            check("stream_ovf", 32'(bus.out_ovf), 32'd0);
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("stream_count", 32'(cnt16), 32'd0);

        // overflow values
        cycle(1'b1, 32'h0000_8000, 1'b1, 1'b0, 1'b0);
`ifdef SIGN_NARROW_SAT_EN
        check("ovf_pos_data", 32'(bus.out_data), 32'h7FFF);
`else
        check("ovf_pos_data", 32'(bus.out_data), 32'h8000);
`endif
        check("ovf_pos_flag", 32'(bus.out_ovf), 32'd1);
        cycle(1'b1, 32'hFFFF_7FFF, 1'b1, 1'b0, 1'b0);
`ifdef SIGN_NARROW_SAT_EN
        check("ovf_neg_data", 32'(bus.out_data), 32'h8000);
`else
        check("ovf_neg_data", 32'(bus.out_data), 32'h7FFF);
`endif
        check("ovf_neg_flag", 32'(bus.out_ovf), 32'd1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("ovf_count_two", 32'(cnt16), 32'd2);

        // backpressure: third word must be refused
        cycle(1'b1, 32'h0000_0011, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0022, 1'b0, 1'b0, 1'b0);
        check("bp_full_ready", 32'(bus.in_ready), 32'd0);
        cycle(1'b1, 32'h0000_0033, 1'b0, 1'b0, 1'b0);
        check("bp_hold_data", 32'(bus.out_data), 32'h0011);
        check("bp_still_full", 32'(bus.in_ready), 32'd0);
        cycle(1'b1, 32'h0000_0033, 1'b1, 1'b0, 1'b0);
        check("bp_ready_back", 32'(bus.in_ready), 32'd1);
        check("bp_second", 32'(bus.out_data), 32'h0022);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // counter saturation and clear priority
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        check("sat_hold", 32'(cnt2), 32'd3);
        check("sat_wide", 32'(cnt16), 32'd5);
        cycle(1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
        check("clear_prio", 32'(cnt2), 32'd0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // reset while two words are buffered
        cycle(1'b1, 32'h0000_0AAA, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0BBB, 1'b0, 1'b0, 1'b0);
        check("mid_full", 32'(bus.in_ready), 32'd0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 9) < 7, rand_word(), $urandom_range(0, 9) < 6,
                  $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
